// File: rtl/apb_master_arb.sv
// apb_master_arb
// Shares one APB master port among N_REQ local requesters using round-robin
// arbitration. Every granted request runs exactly one SETUP and one ACCESS
// cycle (this bus has no pready/pslverr). The owner of each transfer gets a
// one-cycle completion pulse and, for reads, the captured read data.

module apb_master_arb #(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic [AW-1:0]       paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DW-1:0]       pwdata,
  input  logic [DW-1:0]       prdata
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   w_winner;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_nextPtr;
  logic            w_found;
  logic            w_arbEn;
  logic            w_grant;

  logic [AW-1:0]   r_paddr;
  logic            r_pwrite;
  logic [DW-1:0]   r_pwdata;
  logic [N_REQ-1:0] r_rspValid;
  logic [DW-1:0]   r_rspRdata;

  // Rotating priority search: first pending requester at or above the pointer, wrapping around
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // A new transfer may only be accepted while idle or in the last (ACCESS) cycle of the current one
  assign w_arbEn   = (r_state == IDLE) || (r_state == ACCESS);
  assign w_grant   = w_arbEn && w_found;
  assign w_nextPtr = (w_winner == PW'(N_REQ - 1)) ? '0 : (w_winner + 1'b1);

  // One-hot accept pulse, forced low while reset is held so every output reads zero during reset
  always_comb begin
    req_ready = '0;
    if (w_grant && rst) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  // Transfer sequencing: SETUP always follows a grant, ACCESS always follows SETUP
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_nextState = ACCESS;
      end
      ACCESS: begin
        w_nextState = w_grant ? SETUP : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight transfer
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Latch the winner's request fields and owner on a grant; they stay put through ACCESS and IDLE
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
    end else if (w_grant) begin
      r_paddr  <= req_addr[int'(w_winner)*AW +: AW];
      r_pwrite <= req_write[w_winner];
      r_pwdata <= req_wdata[int'(w_winner)*DW +: DW];
      r_owner  <= w_winner;
      r_ptr    <= w_nextPtr;
    end
  end

  // Completion pulse to the owner when ACCESS ends; read data is only updated by reads
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_rspValid <= '0;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= '0;
      if (r_state == ACCESS) begin
        r_rspValid[r_owner] <= 1'b1;
        if (!r_pwrite) begin
          r_rspRdata <= prdata;
        end
      end
    end
  end

  assign psel      = (r_state != IDLE);
  assign penable   = (r_state == ACCESS);
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;

endmodule
